truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Hardware counterpart of an exhaustive K-map stimulus bench. It drives every input combination of a combinational function under test, waits a settle time, and captures the response bit into a minterm vector. It then compares the captured vector against an expected truth table and reports the result. It sits beside a K-map exercise module on the lab board or FPGA and replaces the simulation-only initial-block sweep with synthesizable sequencing.

Parameters:
N_IN, 4, number of function inputs (legal 2..6); x_out[N_IN-1] is x1 (MSB) and x_out[0] is the last input.
SETTLE, 2, extra cycles each vector is held before sampling (legal 0..15).
EXPECTED, 16'h0000, expected truth table with width 2**N_IN; bit k is f for input vector k.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  pulse or level; begins a sweep when sampled high in IDLE or DONE
f_in  input  1  response of the function under test
x_out  output  N_IN  applied input vector
busy  output  1  high while the sweep is running
done  output  1  high in DONE until the next start or reset
minterms  output  2**N_IN  captured truth table; bit k = f_in sampled for vector k
mismatch_cnt  output  N_IN+1  number of captured bits differing from EXPECTED
pass  output  1  high in DONE when mismatch_cnt == 0

Behaviour:
- Single clock domain. rst_n is sampled only on the clk rising edge.
- Reset (rst_n=0 at an edge): state=IDLE, x_out=0, busy=0, done=0, minterms=0, mismatch_cnt=0, pass=0, settle counter=0. Reset mid-sweep aborts immediately with these values and no partial result is kept.
- FSM states:
  - IDLE: outputs at reset values. On start=1 → APPLY, x_out=0, cnt=0, busy=1.
  - APPLY: cnt increments each edge until cnt==SETTLE.
    - At the cnt==SETTLE edge: minterms[x_out] <= f_in, and mismatch_cnt += (f_in != EXPECTED[x_out]).
    - If x_out == 2**N_IN-1 → DONE. Otherwise x_out+1 and cnt=0.
  - DONE: busy=0, done=1, x_out holds its last value, results are held. On start=1 → APPLY with a fresh sweep: minterms, mismatch_cnt, pass, done and x_out all cleared at the same edge.
- Each vector is held for exactly SETTLE+1 cycles. f_in is sampled only at the last edge of that hold; f_in glitches earlier in the hold are ignored.
- Timing relative to the edge (edge 0) that samples start:
  - vector k is captured at edge (k+1)*(SETTLE+1);
  - done=1 and busy=0 become visible after edge 2**N_IN*(SETTLE+1). For defaults this is edge 48.
- pass is registered at the DONE-entry edge and includes the final capture's mismatch. It is never high outside DONE.
- start while busy is ignored; it does not restart or extend the sweep. start held high continuously restarts the sweep immediately after each DONE (one cycle in DONE).
- Simultaneous rst_n=0 and start=1: reset wins.
- mismatch_cnt cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- No combinational path from f_in to any output.

Decomposition:
- Shared package kmap_pkg holds:
  - the state encoding typedef (IDLE, APPLY, DONE);
  - localparams for NUM_VEC = 2**N_IN and the settle counter width;
  - a default EXPECTED constant per lab exercise.
- One natural sub-module, settle_timer: loadable counter with a tick at cnt==SETTLE, cleared by the FSM. Everything else stays in truth_table_sweeper.

Test Plan:
1. Loopback: bench drives f_in = EXPECTED[x_out] with EXPECTED=16'hB3C5 and defaults, start pulsed at edge 0 → done rises after edge 48, minterms=16'hB3C5, mismatch_cnt=0, pass=1, and busy is high for edges 1..48.
2. Inverted response: f_in = ~EXPECTED[x_out] → minterms=16'h4C3A, mismatch_cnt=16, pass=0.
3. Single fault: loopback except vector 5 inverted → minterms=16'hB3E5, mismatch_cnt=1, pass=0, and x_out sequence observed as 0..15 with each value held 3 cycles.
4. Glitch immunity: f_in set wrong for the first 2 cycles of each vector and correct on the sample cycle → pass=1, mismatch_cnt=0.
5. Control corner cases:
   - start re-pulsed at edge 20 → ignored, done still at edge 48;
   - rst_n=0 at edge 30 → all outputs 0 and IDLE at the next cycle;
   - restart from DONE → minterms cleared, new done at +48.
6. Parameter sweep: N_IN=2, SETTLE=0, EXPECTED=4'b0110 with loopback → done after edge 4, minterms=4'b0110, pass=1.

Source files
------------

// File: rtl/kmap_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Holds state encoding, default sizing and lab expected tables.
package kmap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      DONE
   } state_t;

   localparam int DEF_N_IN   = 4;
   localparam int DEF_SETTLE = 2;
   localparam int NUM_VEC    = 2 ** DEF_N_IN;

   // Wide enough for the largest legal settle time (15).
   localparam int CNT_W = 4;

   localparam logic [NUM_VEC-1:0] EXP_DEFAULT = 16'h0000;
   localparam logic [15:0]        EXP_LAB1    = 16'hB3C5;
   localparam logic [3:0]         EXP_XOR2    = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// Hold-time counter for one applied vector.
// Ticks on the cycle whose closing edge samples the response.
module settle_timer
   import kmap_pkg::*;
#(
   parameter int SETTLE = DEF_SETTLE,
   parameter int W      = CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam logic [W-1:0] LIM = W'(SETTLE);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt;

   assign tick = (cnt == LIM);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: applies every vector, captures the response
// bit into a minterm vector and scores it against the expected table.
module truth_table_sweeper
   import kmap_pkg::*;
#(
   parameter int                  N_IN     = DEF_N_IN,
   parameter int                  SETTLE   = DEF_SETTLE,
   parameter logic [2**N_IN-1:0]  EXPECTED = EXP_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 f_in,
   output logic [N_IN-1:0]      x_out,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   minterms,
   output logic [N_IN:0]        mismatch_cnt,
   output logic                 pass
);

   localparam int              NV   = 2 ** N_IN;
   localparam logic [N_IN-1:0] LAST = '1;
   localparam logic [N_IN-1:0] STEP = {{(N_IN-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic [N_IN-1:0]   x_nxt;
   logic [NV-1:0]     min_nxt;
   logic [N_IN:0]     mm_nxt;
   logic              pass_nxt;
   logic              tick;
   logic              clr;
   logic              miss;

   settle_timer #(
      .SETTLE (SETTLE),
      .W      (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   assign miss = (f_in != EXPECTED[x_out]);
   assign busy = (state == APPLY);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      x_nxt     = x_out;
      min_nxt   = minterms;
      mm_nxt    = mismatch_cnt;
      pass_nxt  = pass;
      clr       = 1'b1;
      unique case (state)
         IDLE, DONE: begin
            // A new sweep wipes the previous result in the same edge.
            if (start) begin
               state_nxt = APPLY;
               x_nxt     = '0;
               min_nxt   = '0;
               mm_nxt    = '0;
               pass_nxt  = 1'b0;
            end
         end
         APPLY: begin
            clr = tick;
            if (tick) begin
               min_nxt[x_out] = f_in;
               mm_nxt = mismatch_cnt + {{N_IN{1'b0}}, miss};
               if (x_out == LAST) begin
                  state_nxt = DONE;
                  pass_nxt  = (mm_nxt == '0);
               end else begin
                  x_nxt = x_out + STEP;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         x_out        <= '0;
         minterms     <= '0;
         mismatch_cnt <= '0;
         pass         <= 1'b0;
      end else begin
         state        <= state_nxt;
         x_out        <= x_nxt;
         minterms     <= min_nxt;
         mismatch_cnt <= mm_nxt;
         pass         <= pass_nxt;
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a result scoreboard.
// Covers loopback, inversion, single fault, glitches and control corners.
module tb_truth_table_sweeper;
   import kmap_pkg::*;

   localparam logic [15:0] EXP  = 16'hB3C5;
   localparam logic [3:0]  EXP2 = 4'b0110;

   typedef struct {
      logic [15:0] mt;
      logic [4:0]  mm;
      logic        ps;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        f_in;
   logic [3:0]  x_out;
   logic        busy;
   logic        done;
   logic [15:0] minterms;
   logic [4:0]  mismatch_cnt;
   logic        pass;

   logic        start2;
   logic        f_in2;
   logic [1:0]  x2;
   logic        busy2;
   logic        done2;
   logic [3:0]  minterms2;
   logic [2:0]  mm2;
   logic        pass2;

   logic [15:0] exp_v;
   logic [3:0]  exp2_v;
   logic        ref_bit;
   int          mode;
   logic [1:0]  phase;
   int          checks;
   int          errors;
   exp_t        sb[$];

   truth_table_sweeper #(
      .N_IN     (4),
      .SETTLE   (2),
      .EXPECTED (EXP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .f_in         (f_in),
      .x_out        (x_out),
      .busy         (busy),
      .done         (done),
      .minterms     (minterms),
      .mismatch_cnt (mismatch_cnt),
      .pass         (pass)
   );

   truth_table_sweeper #(
      .N_IN     (2),
      .SETTLE   (0),
      .EXPECTED (EXP2)
   ) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start2),
      .f_in         (f_in2),
      .x_out        (x2),
      .busy         (busy2),
      .done         (done2),
      .minterms     (minterms2),
      .mismatch_cnt (mm2),
      .pass         (pass2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign exp_v   = EXP;
   assign exp2_v  = EXP2;
   assign ref_bit = exp_v[x_out];
   assign f_in2   = exp2_v[x2];

   // Position within the 3-cycle hold; 2 means the next edge samples.
   always @(posedge clk) begin
      if (start && !busy) phase <= 2'd0;
      else if (phase == 2'd2) phase <= 2'd0;
      else phase <= phase + 2'd1;
   end

   always_comb begin
      f_in = ref_bit;
      case (mode)
         1: f_in = ~ref_bit;
         2: f_in = (x_out == 4'd5) ? ~ref_bit : ref_bit;
         3: f_in = (phase == 2'd2) ? ref_bit : ~ref_bit;
         default: f_in = ref_bit;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic sweep(input int md, input logic [15:0] mt,
                        input logic [4:0] mm, input logic ps,
                        input string tag, input int repulse);
      exp_t e;
      int   n;
      int   bad_busy;
      int   bad_x;
      mode = md;
      e.mt = mt;
      e.mm = mm;
      e.ps = ps;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, " fresh"}, {minterms, mismatch_cnt, pass, done, busy},
          {16'h0, 5'h0, 1'b0, 1'b0, 1'b1});
      n = 0;
      bad_busy = 0;
      bad_x = (x_out !== 4'd0) ? 1 : 0;
      while (n < 200) begin
         if (n == repulse - 1) start = 1'b1;
         @(posedge clk);
         #1;
         n++;
         if (n == repulse) start = 1'b0;
         if (done) break;
         if (!busy) bad_busy++;
         if (x_out !== 4'(n / 3)) bad_x++;
      end
      chk({tag, " done_edge"}, n, 48);
      chk({tag, " busy_run"}, bad_busy, 0);
      chk({tag, " x_seq"}, bad_x, 0);
      chk({tag, " busy_done"}, {busy, x_out}, {1'b0, 4'hF});
      e = sb.pop_front();
      chk({tag, " minterms"}, minterms, e.mt);
      chk({tag, " mismatch"}, mismatch_cnt, e.mm);
      chk({tag, " pass"}, pass, e.ps);
   endtask

   initial begin
      int n;
      exp_t e;
      checks = 0;
      errors = 0;
      mode   = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", {x_out, minterms, mismatch_cnt, pass, done, busy}, 32'h0);
      rst_n = 1'b1;

      sweep(0, EXP, 5'd0, 1'b1, "loop", -1);
      repeat (2) @(posedge clk);
      #1;
      chk("hold", {done, pass, minterms}, {1'b1, 1'b1, EXP});
      sweep(1, 16'h4C3A, 5'd16, 1'b0, "inv", -1);
      sweep(2, 16'hB3E5, 5'd1, 1'b0, "fault", -1);
      sweep(3, EXP, 5'd0, 1'b1, "glitch", -1);
      sweep(0, EXP, 5'd0, 1'b1, "repulse", 20);

      // Reset asserted before edge 30 of a sweep aborts it.
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      chk("pre_abort_busy", busy, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort", {x_out, minterms, mismatch_cnt, pass, done, busy}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_idle", {x_out, done, busy}, 6'h0);

      // Reset and start in the same edge: reset wins.
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_wins", {busy, done, x_out}, 6'h0);
      rst_n = 1'b1;
      start = 1'b0;

      // Small configuration: 2 inputs, no settle.
      e.mt = {12'h0, EXP2};
      e.mm = 5'd0;
      e.ps = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (done2) break;
      end
      e = sb.pop_front();
      chk("small done_edge", n, 4);
      chk("small minterms", minterms2, e.mt[3:0]);
      chk("small mismatch", mm2, e.mm[2:0]);
      chk("small pass", pass2, e.ps);

      // Start held high: one cycle in DONE, then a new sweep.
      start2 = 1'b1;
      @(posedge clk);
      #1;
      chk("held restart", {busy2, done2, pass2}, 3'b100);
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (done2) break;
      end
      chk("held done_edge", n, 4);
      @(posedge clk);
      #1;
      chk("held one_cycle", {busy2, done2}, 2'b10);
      start2 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
